// File: rtl/rs_station_pkg.sv
// Shared definitions for the reservation station: op encodings, common field types
// and a helper that classifies register-immediate ALU forms.
package rs_station_pkg;

    localparam int RS_SIZE_DEFAULT = 8;
    localparam int ROB_ID_WIDTH    = 4;
    localparam int OP_WIDTH        = 6;
    localparam int REG_WIDTH       = 5;

    typedef logic [REG_WIDTH-1:0]               reg_t;
    typedef logic [31:0]                        imm_t;
    typedef logic [OP_WIDTH-1:0]                op_t;
    typedef logic [ROB_ID_WIDTH-1:0]            rob_id_t;
    typedef logic [$clog2(RS_SIZE_DEFAULT)-1:0] rs_id_t;
    typedef logic [31:0]                        word_t;

    localparam op_t OP_NOP   = 6'd0;
    localparam op_t OP_LUI   = 6'd1;
    localparam op_t OP_AUIPC = 6'd2;
    localparam op_t OP_JAL   = 6'd3;
    localparam op_t OP_JALR  = 6'd4;
    localparam op_t OP_BEQ   = 6'd5;
    localparam op_t OP_BNE   = 6'd6;
    localparam op_t OP_BLT   = 6'd7;
    localparam op_t OP_BGE   = 6'd8;
    localparam op_t OP_BLTU  = 6'd9;
    localparam op_t OP_BGEU  = 6'd10;
    localparam op_t OP_ADDI  = 6'd11;
    localparam op_t OP_SLTI  = 6'd12;
    localparam op_t OP_SLTIU = 6'd13;
    localparam op_t OP_XORI  = 6'd14;
    localparam op_t OP_ORI   = 6'd15;
    localparam op_t OP_ANDI  = 6'd16;
    localparam op_t OP_SLLI  = 6'd17;
    localparam op_t OP_SRLI  = 6'd18;
    localparam op_t OP_SRAI  = 6'd19;
    localparam op_t OP_ADD   = 6'd20;
    localparam op_t OP_SUB   = 6'd21;
    localparam op_t OP_SLL   = 6'd22;
    localparam op_t OP_SLT   = 6'd23;
    localparam op_t OP_SLTU  = 6'd24;
    localparam op_t OP_XOR   = 6'd25;
    localparam op_t OP_SRL   = 6'd26;
    localparam op_t OP_SRA   = 6'd27;
    localparam op_t OP_OR    = 6'd28;
    localparam op_t OP_AND   = 6'd29;

    // Register-immediate forms take their second operand from imm instead of vk.
    function automatic logic uses_imm(input op_t op);
        case (op)
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
            OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rs_station_alu.sv
// Combinational execute unit: integer result plus resolved next PC for the
// entry the reservation station dispatches this cycle.
module rs_station_alu
    import rs_station_pkg::*;
(
    input  logic [OP_WIDTH-1:0] op,
    input  logic [31:0]         vj,
    input  logic [31:0]         vk,
    input  logic [31:0]         imm,
    input  logic [31:0]         pc,
    output logic [31:0]         value,
    output logic [31:0]         next_pc
);

    word_t      b;
    logic [4:0] shamt;
    word_t      seq_pc;
    word_t      target;

    always_comb begin
        b       = uses_imm(op) ? imm : vk;
        shamt   = b[4:0];
        seq_pc  = pc + 32'd4;
        target  = pc + imm;
        value   = '0;
        next_pc = seq_pc;
        case (op)
            OP_LUI:   value = imm;
            OP_AUIPC: value = target;
            OP_JAL: begin
                value   = seq_pc;
                next_pc = target;
            end
            OP_JALR: begin
                value   = seq_pc;
                next_pc = (vj + imm) & ~32'd1;
            end
            // Branches leave value at zero; only the PC outcome matters.
            OP_BEQ:  next_pc = (vj == vk) ? target : seq_pc;
            OP_BNE:  next_pc = (vj != vk) ? target : seq_pc;
            OP_BLT:  next_pc = ($signed(vj) <  $signed(vk)) ? target : seq_pc;
            OP_BGE:  next_pc = ($signed(vj) >= $signed(vk)) ? target : seq_pc;
            OP_BLTU: next_pc = (vj <  vk) ? target : seq_pc;
            OP_BGEU: next_pc = (vj >= vk) ? target : seq_pc;
            OP_ADD, OP_ADDI:   value = vj + b;
            OP_SUB:            value = vj - vk;
            OP_SLL, OP_SLLI:   value = vj << shamt;
            OP_SLT, OP_SLTI:   value = {31'd0, $signed(vj) < $signed(b)};
            OP_SLTU, OP_SLTIU: value = {31'd0, vj < b};
            OP_XOR, OP_XORI:   value = vj ^ b;
            OP_SRL, OP_SRLI:   value = vj >> shamt;
            OP_SRA, OP_SRAI:   value = word_t'($signed(vj) >>> shamt);
            OP_OR, OP_ORI:     value = vj | b;
            OP_AND, OP_ANDI:   value = vj & b;
            default: ;
        endcase
    end

endmodule

// File: rtl/rs_station.sv
// Reservation station for non-memory ops: captures issued entries, snoops the rss/lsb
// result buses, dispatches the lowest-index ready entry and broadcasts its result.
module rs_station
    import rs_station_pkg::*;
#(
    parameter int RS_SIZE  = 8,
    parameter int ROB_ID_W = 4,
    parameter int OP_W     = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                reset_from_rob_bus,
    input  logic [ROB_ID_W-1:0] dest_from_issuer,
    input  logic [OP_W-1:0]     op_from_issuer,
    input  logic [ROB_ID_W-1:0] qj_from_issuer,
    input  logic [ROB_ID_W-1:0] qk_from_issuer,
    input  logic [31:0]         vj_from_issuer,
    input  logic [31:0]         vk_from_issuer,
    input  logic [31:0]         imm_from_issuer,
    input  logic [31:0]         pc_from_issuer,
    input  logic [ROB_ID_W-1:0] dest_from_lsb_bus,
    input  logic [31:0]         value_from_lsb_bus,
    output logic                is_full,
    output logic [ROB_ID_W-1:0] dest_to_rss_bus,
    output logic [31:0]         value_to_rss_bus,
    output logic [31:0]         next_pc_to_rss_bus
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_SIZE-1:0]  busy_q, busy_d;
    logic [OP_W-1:0]     op_q   [RS_SIZE];
    logic [OP_W-1:0]     op_d   [RS_SIZE];
    logic [ROB_ID_W-1:0] qj_q   [RS_SIZE];
    logic [ROB_ID_W-1:0] qj_d   [RS_SIZE];
    logic [ROB_ID_W-1:0] qk_q   [RS_SIZE];
    logic [ROB_ID_W-1:0] qk_d   [RS_SIZE];
    logic [31:0]         vj_q   [RS_SIZE];
    logic [31:0]         vj_d   [RS_SIZE];
    logic [31:0]         vk_q   [RS_SIZE];
    logic [31:0]         vk_d   [RS_SIZE];
    logic [31:0]         imm_q  [RS_SIZE];
    logic [31:0]         imm_d  [RS_SIZE];
    logic [31:0]         pc_q   [RS_SIZE];
    logic [31:0]         pc_d   [RS_SIZE];
    logic [ROB_ID_W-1:0] dest_q [RS_SIZE];
    logic [ROB_ID_W-1:0] dest_d [RS_SIZE];

    logic [ROB_ID_W-1:0] dest_out_q, dest_out_d;
    logic [31:0]         value_out_q, value_out_d;
    logic [31:0]         npc_out_q, npc_out_d;

    logic             issue_vld;
    logic             alloc;
    logic             dispatch;
    logic             free_vld;
    logic [IDX_W-1:0] free_idx;
    logic             ready_vld;
    logic [IDX_W-1:0] disp_idx;
    logic [CNT_W-1:0] busy_cnt;
    logic [31:0]      alu_value;
    logic [31:0]      alu_npc;

    // Returns {tag, value} after checking the operand tag against both result buses;
    // the station's own broadcast takes precedence and a zero tag never matches.
    function automatic logic [ROB_ID_W+31:0] resolve(
        input logic [ROB_ID_W-1:0] q,
        input logic [31:0]         v,
        input logic [ROB_ID_W-1:0] rss_tag,
        input logic [31:0]         rss_val,
        input logic [ROB_ID_W-1:0] lsb_tag,
        input logic [31:0]         lsb_val
    );
        if (q != '0 && q == rss_tag) return {{ROB_ID_W{1'b0}}, rss_val};
        if (q != '0 && q == lsb_tag) return {{ROB_ID_W{1'b0}}, lsb_val};
        return {q, v};
    endfunction

    // Descending scan so the lowest index wins both priority encoders.
    always_comb begin
        free_vld  = 1'b0;
        free_idx  = '0;
        ready_vld = 1'b0;
        disp_idx  = '0;
        busy_cnt  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0) begin
                ready_vld = 1'b1;
                disp_idx  = IDX_W'(i);
            end
            busy_cnt = busy_cnt + CNT_W'(busy_q[i]);
        end
    end

    assign issue_vld = (dest_from_issuer != '0);
    assign alloc     = issue_vld && free_vld && !reset_from_rob_bus;
    assign dispatch  = rdy && !reset_from_rob_bus && ready_vld;
    assign is_full   = (busy_cnt + CNT_W'(issue_vld)) >= CNT_W'(RS_SIZE);

    rs_station_alu u_alu (
        .op      (op_q[disp_idx]),
        .vj      (vj_q[disp_idx]),
        .vk      (vk_q[disp_idx]),
        .imm     (imm_q[disp_idx]),
        .pc      (pc_q[disp_idx]),
        .value   (alu_value),
        .next_pc (alu_npc)
    );

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            op_d[i]   = op_q[i];
            qj_d[i]   = qj_q[i];
            qk_d[i]   = qk_q[i];
            vj_d[i]   = vj_q[i];
            vk_d[i]   = vk_q[i];
            imm_d[i]  = imm_q[i];
            pc_d[i]   = pc_q[i];
            dest_d[i] = dest_q[i];
            if (rdy && busy_q[i]) begin
                {qj_d[i], vj_d[i]} = resolve(qj_q[i], vj_q[i], dest_out_q, value_out_q,
                                             dest_from_lsb_bus, value_from_lsb_bus);
                {qk_d[i], vk_d[i]} = resolve(qk_q[i], vk_q[i], dest_out_q, value_out_q,
                                             dest_from_lsb_bus, value_from_lsb_bus);
            end
            if (dispatch && disp_idx == IDX_W'(i)) begin
                busy_d[i] = 1'b0;
            end
            // free_idx comes from the pre-dispatch vector, so it never aliases disp_idx.
            if (alloc && free_idx == IDX_W'(i)) begin
                busy_d[i] = 1'b1;
                op_d[i]   = op_from_issuer;
                imm_d[i]  = imm_from_issuer;
                pc_d[i]   = pc_from_issuer;
                dest_d[i] = dest_from_issuer;
                {qj_d[i], vj_d[i]} = resolve(qj_from_issuer, vj_from_issuer, dest_out_q,
                                             value_out_q, dest_from_lsb_bus, value_from_lsb_bus);
                {qk_d[i], vk_d[i]} = resolve(qk_from_issuer, vk_from_issuer, dest_out_q,
                                             value_out_q, dest_from_lsb_bus, value_from_lsb_bus);
            end
        end
        if (reset_from_rob_bus) begin
            busy_d = '0;
        end
    end

    always_comb begin
        dest_out_d  = '0;
        value_out_d = value_out_q;
        npc_out_d   = npc_out_q;
        if (dispatch) begin
            dest_out_d  = dest_q[disp_idx];
            value_out_d = alu_value;
            npc_out_d   = alu_npc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q      <= '0;
            dest_out_q  <= '0;
            value_out_q <= '0;
            npc_out_q   <= '0;
        end else begin
            busy_q      <= busy_d;
            dest_out_q  <= dest_out_d;
            value_out_q <= value_out_d;
            npc_out_q   <= npc_out_d;
            assert (!(issue_vld && !free_vld && !reset_from_rob_bus))
                else $error("rs_station: issue received with no free entry, entry dropped");
        end
    end

    // Entry payload needs no reset: busy gates every use of it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            op_q[i]   <= op_d[i];
            qj_q[i]   <= qj_d[i];
            qk_q[i]   <= qk_d[i];
            vj_q[i]   <= vj_d[i];
            vk_q[i]   <= vk_d[i];
            imm_q[i]  <= imm_d[i];
            pc_q[i]   <= pc_d[i];
            dest_q[i] <= dest_d[i];
        end
    end

    assign dest_to_rss_bus    = dest_out_q;
    assign value_to_rss_bus   = value_out_q;
    assign next_pc_to_rss_bus = npc_out_q;

endmodule

// File: tb/tb_rs_station.sv
// Bench for rs_station: directed scenarios followed by random traffic, all checked
// against a behavioural model of the station's entry table and result bus.
module tb_rs_station;
    import rs_station_pkg::*;

    localparam int RS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic [3:0]  dest_i, qj_i, qk_i, lsb_dest;
    logic [5:0]  op_i;
    logic [31:0] vj_i, vk_i, imm_i, pc_i, lsb_val;
    logic        is_full;
    logic [3:0]  dest_o;
    logic [31:0] value_o, npc_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model: table of pending instructions and the expected bus contents.
    logic        mbusy [RS];
    logic [5:0]  mop   [RS];
    logic [3:0]  mqj   [RS];
    logic [3:0]  mqk   [RS];
    logic [3:0]  mdest [RS];
    logic [31:0] mvj   [RS];
    logic [31:0] mvk   [RS];
    logic [31:0] mimm  [RS];
    logic [31:0] mpc   [RS];
    logic [3:0]  e_dest;
    logic [31:0] e_value, e_npc;

    rs_station dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .reset_from_rob_bus (flush),
        .dest_from_issuer   (dest_i),
        .op_from_issuer     (op_i),
        .qj_from_issuer     (qj_i),
        .qk_from_issuer     (qk_i),
        .vj_from_issuer     (vj_i),
        .vk_from_issuer     (vk_i),
        .imm_from_issuer    (imm_i),
        .pc_from_issuer     (pc_i),
        .dest_from_lsb_bus  (lsb_dest),
        .value_from_lsb_bus (lsb_val),
        .is_full            (is_full),
        .dest_to_rss_bus    (dest_o),
        .value_to_rss_bus   (value_o),
        .next_pc_to_rss_bus (npc_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int mcount();
        int n = 0;
        for (int i = 0; i < RS; i++) n += mbusy[i] ? 1 : 0;
        return n;
    endfunction

    // Architectural result of one instruction.
    function automatic void ref_exec(input logic [5:0] op, input logic [31:0] a, b, imm, pc,
                                     output logic [31:0] v, output logic [31:0] npc);
        v   = 32'd0;
        npc = pc + 32'd4;
        case (op)
            OP_LUI:   v = imm;
            OP_AUIPC: v = pc + imm;
            OP_JAL:   begin v = pc + 32'd4; npc = pc + imm; end
            OP_JALR:  begin v = pc + 32'd4; npc = (a + imm) & 32'hFFFF_FFFE; end
            OP_BEQ:   if (a == b) npc = pc + imm;
            OP_BNE:   if (a != b) npc = pc + imm;
            OP_BLT:   if ($signed(a) < $signed(b)) npc = pc + imm;
            OP_BGE:   if ($signed(a) >= $signed(b)) npc = pc + imm;
            OP_BLTU:  if (a < b) npc = pc + imm;
            OP_BGEU:  if (a >= b) npc = pc + imm;
            OP_ADDI:  v = a + imm;
            OP_SLTI:  v = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            OP_SLTIU: v = (a < imm) ? 32'd1 : 32'd0;
            OP_XORI:  v = a ^ imm;
            OP_ORI:   v = a | imm;
            OP_ANDI:  v = a & imm;
            OP_SLLI:  v = a << imm[4:0];
            OP_SRLI:  v = a >> imm[4:0];
            OP_SRAI:  v = $signed(a) >>> imm[4:0];
            OP_ADD:   v = a + b;
            OP_SUB:   v = a - b;
            OP_SLL:   v = a << b[4:0];
            OP_SLT:   v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:  v = (a < b) ? 32'd1 : 32'd0;
            OP_XOR:   v = a ^ b;
            OP_SRL:   v = a >> b[4:0];
            OP_SRA:   v = $signed(a) >>> b[4:0];
            OP_OR:    v = a | b;
            OP_AND:   v = a & b;
            default: ;
        endcase
    endfunction

    // An operand waiting on tag q picks up whichever bus currently carries q.
    function automatic logic [35:0] snoop(input logic [3:0] q, input logic [31:0] v,
                                          input logic [3:0] bt, input logic [31:0] bv);
        if (q != 4'd0 && q == bt)       return {4'd0, bv};
        if (q != 4'd0 && q == lsb_dest) return {4'd0, lsb_val};
        return {q, v};
    endfunction

    task automatic set_issue(input logic [5:0] op, input logic [3:0] d, qj, qk,
                             input logic [31:0] vj, vk, imm, pc);
        op_i = op; dest_i = d; qj_i = qj; qk_i = qk;
        vj_i = vj; vk_i = vk; imm_i = imm; pc_i = pc;
    endtask

    // One clock: check is_full, advance the model across the edge, check the bus.
    task automatic tick();
        int          sel, fr, inc;
        logic [3:0]  bt;
        logic [31:0] bv, rv, rn;
        #1;
        inc = (dest_i != 4'd0) ? 1 : 0;
        check("is_full", {31'd0, is_full}, (mcount() + inc >= RS) ? 32'd1 : 32'd0);
        bt = e_dest;
        bv = e_value;
        if (flush) begin
            for (int i = 0; i < RS; i++) mbusy[i] = 1'b0;
            e_dest = 4'd0;
        end else begin
            sel = -1;
            fr  = -1;
            for (int i = RS - 1; i >= 0; i--) begin
                if (!mbusy[i]) fr = i;
                if (rdy && mbusy[i] && mqj[i] == 4'd0 && mqk[i] == 4'd0) sel = i;
            end
            e_dest = 4'd0;
            if (sel >= 0) begin
                ref_exec(mop[sel], mvj[sel], mvk[sel], mimm[sel], mpc[sel], rv, rn);
                e_dest   = mdest[sel];
                e_value  = rv;
                e_npc    = rn;
                mbusy[sel] = 1'b0;
            end
            if (rdy) begin
                for (int i = 0; i < RS; i++) begin
                    if (mbusy[i]) begin
                        {mqj[i], mvj[i]} = snoop(mqj[i], mvj[i], bt, bv);
                        {mqk[i], mvk[i]} = snoop(mqk[i], mvk[i], bt, bv);
                    end
                end
            end
            if (dest_i != 4'd0 && fr >= 0) begin
                mbusy[fr] = 1'b1;
                mop[fr]   = op_i;
                mdest[fr] = dest_i;
                mimm[fr]  = imm_i;
                mpc[fr]   = pc_i;
                {mqj[fr], mvj[fr]} = snoop(qj_i, vj_i, bt, bv);
                {mqk[fr], mvk[fr]} = snoop(qk_i, vk_i, bt, bv);
            end
        end
        @(posedge clk);
        #1;
        check("bus_dest", {28'd0, dest_o}, {28'd0, e_dest});
        if (e_dest != 4'd0) begin
            check("bus_value", value_o, e_value);
            check("bus_next_pc", npc_o, e_npc);
        end
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        lsb_dest = 4'd0; lsb_val = 32'd0;
        set_issue(6'd0, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < RS; i++) mbusy[i] = 1'b0;
        e_dest = 4'd0; e_value = 32'd0; e_npc = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_dest", {28'd0, dest_o}, 32'd0);
        check("reset_value", value_o, 32'd0);
        check("reset_next_pc", npc_o, 32'd0);
        check("reset_is_full", {31'd0, is_full}, 32'd0);
        rst = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_dest", {28'd0, dest_o}, 32'd0);
        end

        // Single ready ADD: broadcast two edges after issue, then idle
        set_issue(OP_ADD, 4'd3, 4'd0, 4'd0, 32'd5, 32'd7, 32'd0, 32'h40);
        tick();
        dest_i = 4'd0;
        tick();
        check("add_dest", {28'd0, dest_o}, 32'd3);
        check("add_value", value_o, 32'd12);
        check("add_next_pc", npc_o, 32'h44);
        tick();
        check("add_idle", {28'd0, dest_o}, 32'd0);

        // Wakeup chain through the station's own bus
        set_issue(OP_SUB, 4'd2, 4'd0, 4'd0, 32'd10, 32'd4, 32'd0, 32'h80);
        tick();
        set_issue(OP_ADDI, 4'd4, 4'd2, 4'd0, 32'd0, 32'd0, 32'd1, 32'h84);
        tick();
        check("sub_dest", {28'd0, dest_o}, 32'd2);
        check("sub_value", value_o, 32'd6);
        dest_i = 4'd0;
        tick();
        tick();
        check("addi_dest", {28'd0, dest_o}, 32'd4);
        check("addi_value", value_o, 32'd7);
        tick();

        // Wakeup from the lsb bus on qk
        set_issue(OP_ADD, 4'd6, 4'd0, 4'd5, 32'd1, 32'd0, 32'd0, 32'hC0);
        tick();
        dest_i = 4'd0;
        lsb_dest = 4'd5; lsb_val = 32'h100;
        tick();
        lsb_dest = 4'd0; lsb_val = 32'd0;
        tick();
        check("lsbwake_dest", {28'd0, dest_o}, 32'd6);
        check("lsbwake_value", value_o, 32'h101);
        tick();

        // Same-cycle capture from the lsb bus at allocation
        set_issue(OP_ADD, 4'd7, 4'd6, 4'd0, 32'd0, 32'd2, 32'd0, 32'h100);
        lsb_dest = 4'd6; lsb_val = 32'd9;
        tick();
        dest_i = 4'd0; lsb_dest = 4'd0; lsb_val = 32'd0;
        tick();
        check("capture_dest", {28'd0, dest_o}, 32'd7);
        check("capture_value", value_o, 32'd11);
        tick();

        // Fill with never-resolved dependents, then flush
        for (int k = 0; k < RS; k++) begin
            set_issue(OP_ADD, 4'(k + 1), 4'd7, 4'd0, 32'd1, 32'd1, 32'd0, 32'h200);
            #1;
            check("full_rise", {31'd0, is_full}, (k == RS - 1) ? 32'd1 : 32'd0);
            tick();
        end
        dest_i = 4'd0;
        #1;
        check("full_held", {31'd0, is_full}, 32'd1);
        flush = 1'b1;
        set_issue(OP_ADD, 4'd9, 4'd0, 4'd0, 32'd3, 32'd3, 32'd0, 32'h300);
        tick();
        flush = 1'b0;
        dest_i = 4'd0;
        #1;
        check("flush_is_full", {31'd0, is_full}, 32'd0);
        check("flush_dest", {28'd0, dest_o}, 32'd0);
        lsb_dest = 4'd7; lsb_val = 32'd55;
        tick();
        lsb_dest = 4'd0; lsb_val = 32'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_quiet", {28'd0, dest_o}, 32'd0);
        end

        // Branch and jump results
        set_issue(OP_BEQ, 4'd1, 4'd0, 4'd0, 32'd1, 32'd1, 32'h20, 32'h100);
        tick();
        set_issue(OP_JALR, 4'd2, 4'd0, 4'd0, 32'h203, 32'd0, 32'd4, 32'h300);
        tick();
        check("beq_next_pc", npc_o, 32'h120);
        check("beq_value", value_o, 32'd0);
        dest_i = 4'd0;
        tick();
        check("jalr_next_pc", npc_o, 32'h206);
        check("jalr_value", value_o, 32'h304);
        tick();

        // Allocation while rdy is low; dispatch waits for rdy
        rdy = 1'b0;
        set_issue(OP_ADD, 4'd5, 4'd0, 4'd0, 32'd1, 32'd1, 32'd0, 32'h400);
        tick();
        dest_i = 4'd0;
        tick();
        check("stall_dest", {28'd0, dest_o}, 32'd0);
        rdy = 1'b1;
        tick();
        check("resume_dest", {28'd0, dest_o}, 32'd5);
        check("resume_value", value_o, 32'd2);
        tick();

        // Random traffic against the model
        for (int c = 0; c < 800; c++) begin
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) begin
                lsb_dest = 4'($urandom_range(12, 15));
                lsb_val  = $urandom();
            end else begin
                lsb_dest = 4'd0;
                lsb_val  = 32'd0;
            end
            if (mcount() < RS && $urandom_range(0, 2) != 0) begin
                op_i   = 6'($urandom_range(1, 29));
                dest_i = 4'($urandom_range(1, 11));
                qj_i   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                qk_i   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                vj_i   = $urandom();
                vk_i   = ($urandom_range(0, 3) == 0) ? vj_i : $urandom();
                imm_i  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom();
                pc_i   = $urandom() & 32'hFFFF_FFFC;
            end else begin
                dest_i = 4'd0;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
